seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter DIV, default 50000: clock cycles each digit occupies per scan slot, minimum 4.
REQ-003 Parameter BLANK_CYC, default 2: dead cycles at the start of each slot with all anodes off; SHALL be less than DIV.
REQ-004 Parameter AN_ACTIVE_LOW, default 1: 1 drives the selected anode low, 0 drives it high.
REQ-005 clk  input  1  single clock; every register updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 load  input  1  one-cycle strobe that latches value, dp, dig_en and bcd_mode into shadow registers.
REQ-008 value  input  4*DIGITS  packed nibbles, digit 0 in bits [3:0].
REQ-009 dp  input  DIGITS  per-digit decimal point request, 1 = lit.
REQ-010 dig_en  input  DIGITS  per-digit enable; a disabled digit shows blank.
REQ-011 bcd_mode  input  1  1 = nibbles above 9 render as dash; 0 = hex.
REQ-012 lz_blank  input  1  leading-zero blanking enable, sampled live and not shadowed.
REQ-013 seg  output  7  segments abcdefg, bit 6 = a, always active-low.
REQ-014 seg_dp  output  1  decimal point, active-low.
REQ-015 an  output  DIGITS  digit select, polarity set by AN_ACTIVE_LOW.
REQ-016 slot_idx  output  3  index of the digit currently being scanned.

Function
REQ-017 Glyphs (hex): 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38, dash=7E, blank=7F.
REQ-018 Scan FSM SHALL have two states, BLANK and SHOW, with a prescaler counting 0..DIV-1 within each slot.
REQ-019 BLANK lasts while the prescaler is below BLANK_CYC; SHOW covers prescaler values BLANK_CYC..DIV-1.
REQ-020 When the prescaler reaches DIV-1, it SHALL wrap to 0, the state SHALL return to BLANK, and slot_idx SHALL advance, wrapping DIGITS-1 -> 0.
REQ-021 In BLANK, an SHALL be all inactive, seg SHALL be 7F and seg_dp SHALL be 1.
REQ-022 In SHOW, exactly one an bit (bit slot_idx) SHALL be active; seg SHALL show the glyph for the shadowed nibble and seg_dp SHALL be the inverse of shadowed dp[slot_idx].
REQ-023 seg, seg_dp and an SHALL be registered, lagging the FSM state and slot_idx by one cycle.
REQ-024 Blank glyph takes priority: shown if dig_en[i]=0, or if the digit is leading-zero-blanked.
REQ-025 Dash glyph, where blank does not apply: shown if bcd_mode=1 and the nibble is above 9.
REQ-026 Otherwise the hex glyph SHALL be shown.
REQ-027 Leading-zero blank: with lz_blank=1, digit i>0 is blanked when nibble i and all higher nibbles are 0; digit 0 is never blanked by this rule.
REQ-028 Suppressing a leading zero SHALL also suppress that digit's dp.
REQ-029 A load SHALL update the shadow registers on the next edge without disturbing the prescaler, the state or slot_idx; new data is visible on pins one cycle later.
REQ-030 Back-to-back loads SHALL each take effect; the last one wins.
REQ-031 When DIGITS=1, slot_idx SHALL stay 0 and the FSM SHALL still alternate BLANK/SHOW.

Reset
REQ-032 While rst=1, the block SHALL force: prescaler=0, state=BLANK, slot_idx=0, shadow value=0, shadow dp=0, shadow dig_en=0, shadow bcd_mode=0.
REQ-033 On the first edge after reset, the block SHALL output seg=7F, seg_dp=1 and an all inactive.
REQ-034 rst SHALL override a simultaneous load.
REQ-035 rst asserted mid-slot SHALL restart the scan at slot 0 in BLANK.

Verification
REQ-036 Test parameters: DIGITS=4, DIV=8, BLANK_CYC=2, AN_ACTIVE_LOW=1.
- Load value=16'h12AF, dig_en=F, bcd_mode=0 -> slot 0 SHOW: an=1110, seg=38; slot 1: seg=08; slot 2: seg=12; slot 3: seg=4F; 2 blank cycles per 8-cycle slot.
- Same value with bcd_mode=1 -> slots 0 and 1 show 7E; slots 2 and 3 unchanged.
- value=16'h0040, lz_blank=1, dp=4'b1000 -> digits 3 and 2 show 7F with seg_dp=1; digit 1 shows 4C; digit 0 shows 01.
- value=0, lz_blank=1 -> only digit 0 lit, seg=01.
- Load with new value during SHOW of slot 1 -> seg changes 2 cycles after the load edge; slot timing unchanged.
- rst pulse during slot 2 -> next cycle slot_idx=0, an=1111, seg=7F; after reset, dig_en=0 keeps every slot blank until a load.

Source files
------------

// File: rtl/seg_scan.sv
// Multiplexed seven-segment scanner: shadowed digit data, per-slot blanking
// interval, leading-zero suppression and registered segment/anode drive.
module seg_scan #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned DIV           = 50000,
  parameter int unsigned BLANK_CYC     = 2,
  parameter int unsigned AN_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     dig_en,
  input  logic                  bcd_mode,
  input  logic                  lz_blank,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic [2:0]            slot_idx
);

  localparam int unsigned CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYC);
  localparam logic [2:0]  SLOT_MAX   = 3'(DIGITS - 1);
  localparam logic        AN_OFF     = (AN_ACTIVE_LOW != 0);
  localparam logic [6:0]  GLYPH_BLANK = 7'h7F;
  localparam logic [6:0]  GLYPH_DASH  = 7'h7E;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, cnt_nxt;
  logic [2:0]          slot_nxt;

  logic [4*DIGITS-1:0] val_q;
  logic [DIGITS-1:0]   dp_q;
  logic [DIGITS-1:0]   en_q;
  logic                bcd_q;

  logic [DIGITS-1:0]   lz_mask;
  logic                upper_zero;
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_en;
  logic                sel_lz;
  logic [DIGITS-1:0]   sel_an;

  logic [6:0]          seg_nxt;
  logic                seg_dp_nxt;
  logic [DIGITS-1:0]   an_nxt;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h01;
      4'h1: g = 7'h4F;
      4'h2: g = 7'h12;
      4'h3: g = 7'h06;
      4'h4: g = 7'h4C;
      4'h5: g = 7'h24;
      4'h6: g = 7'h20;
      4'h7: g = 7'h0F;
      4'h8: g = 7'h00;
      4'h9: g = 7'h04;
      4'hA: g = 7'h08;
      4'hB: g = 7'h60;
      4'hC: g = 7'h31;
      4'hD: g = 7'h42;
      4'hE: g = 7'h30;
      default: g = 7'h38;
    endcase
    return g;
  endfunction

  // Scan state register: prescaler, phase and slot pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      state    <= BLANK;
      slot_idx <= '0;
    end else begin
      cnt      <= cnt_nxt;
      state    <= state_nxt;
      slot_idx <= slot_nxt;
    end
  end

  // Shadow copy of the display data; loads never touch the scan timing
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      dp_q  <= '0;
      en_q  <= '0;
      bcd_q <= 1'b0;
    end else if (load) begin
      val_q <= value;
      dp_q  <= dp;
      en_q  <= dig_en;
      bcd_q <= bcd_mode;
    end
  end

  // Digit i>0 is a leading zero when it and every higher nibble are zero
  always_comb begin
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (val_q[4*i +: 4] == 4'h0);
      if (i > 0) lz_mask[i] = lz_blank & upper_zero;
    end
  end

  // Pick out the data belonging to the slot being scanned
  always_comb begin
    sel_nib = '0;
    sel_dp  = 1'b0;
    sel_en  = 1'b0;
    sel_lz  = 1'b0;
    sel_an  = {DIGITS{AN_OFF}};
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (slot_idx == 3'(i)) begin
        sel_nib   = val_q[4*i +: 4];
        sel_dp    = dp_q[i];
        sel_en    = en_q[i];
        sel_lz    = lz_mask[i];
        sel_an[i] = ~AN_OFF;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    cnt_nxt    = cnt + CW'(1);
    state_nxt  = state;
    slot_nxt   = slot_idx;
    seg_nxt    = GLYPH_BLANK;
    seg_dp_nxt = 1'b1;
    an_nxt     = {DIGITS{AN_OFF}};

    if (cnt == CNT_MAX) begin
      cnt_nxt   = '0;
      state_nxt = BLANK;
      slot_nxt  = (slot_idx == SLOT_MAX) ? 3'd0 : slot_idx + 3'd1;
    end
    if (cnt_nxt == CNT_SHOW) state_nxt = SHOW;

    if (state == SHOW) begin
      an_nxt = sel_an;
      if (!sel_en || sel_lz)            seg_nxt = GLYPH_BLANK;
      else if (bcd_q && sel_nib > 4'd9) seg_nxt = GLYPH_DASH;
      else                              seg_nxt = hex_glyph(sel_nib);
      // A suppressed leading zero also hides its decimal point
      seg_dp_nxt = ~(sel_dp & ~sel_lz);
    end
  end

  // Registered pin drive, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      seg    <= GLYPH_BLANK;
      seg_dp <= 1'b1;
      an     <= {DIGITS{AN_OFF}};
    end else begin
      seg    <= seg_nxt;
      seg_dp <= seg_dp_nxt;
      an     <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan (DIGITS=4, DIV=8, BLANK_CYC=2, active-low anodes).
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  dig_en;
  logic        bcd_mode;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic [2:0]  slot_idx;

  seg_scan #(.DIGITS(4), .DIV(8), .BLANK_CYC(2), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .dig_en(dig_en), .bcd_mode(bcd_mode), .lz_blank(lz_blank),
    .seg(seg), .seg_dp(seg_dp), .an(an), .slot_idx(slot_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] slot;
  } obs_t;

  obs_t        q[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int          k      = 0;
  string       tname  = "reset";
  logic [6:0]  tseg[4];
  logic [3:0]  tdpn;

  // Monitor: every sampled cycle with a pending expectation is compared
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {an, seg, seg_dp, slot_idx};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s k=%0d: got an=%b seg=%h dp=%b slot=%0d, want an=%b seg=%h dp=%b slot=%0d",
                    tname, k, a.an, a.seg, a.dp, a.slot, e.an, e.seg, e.dp, e.slot);
    end
  end

  // Expected pins after the k-th edge since reset (8-cycle slots, 2 blank)
  function automatic obs_t expect_at(input int kk);
    obs_t o;
    int ph;
    int os;
    o = {4'hF, 7'h7F, 1'b1, 3'd0};
    if (kk > 0) begin
      ph = (kk - 1) % 8;
      os = ((kk - 1) / 8) % 4;
      if (ph >= 2) begin
        o.an  = 4'(~(4'b0001 << os));
        o.seg = tseg[os];
        o.dp  = tdpn[os];
      end
      o.slot = 3'((kk / 8) % 4);
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rst) k = 0;
    else k++;
    q.push_back(expect_at(k));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int ph);
    for (int g = 0; g < 64 && (k % 32) != ph; g++) step();
  endtask

  task automatic set_tab(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] dn);
    tseg[0] = s0; tseg[1] = s1; tseg[2] = s2; tseg[3] = s3;
    tdpn = dn;
  endtask

  // Load strobe; new glyphs reach the pins on the second edge
  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en,
                         input logic bcd, input logic lz,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] dn);
    value = v; dp = d; dig_en = en; bcd_mode = bcd; load = 1'b1;
    step();
    load = 1'b0;
    lz_blank = lz;
    set_tab(s0, s1, s2, s3, dn);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; dig_en = '0;
    bcd_mode = 1'b0; lz_blank = 1'b0;
    set_tab(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    run(2);
    rst = 1'b0;
    tname = "after_reset";
    run(16);

    tname = "hex_12AF";
    do_load(16'h12AF, 4'b0000, 4'hF, 1'b0, 1'b0, 7'h38, 7'h08, 7'h12, 7'h4F, 4'hF);
    run(40);

    tname = "bcd_12AF";
    do_load(16'h12AF, 4'b0000, 4'hF, 1'b1, 1'b0, 7'h7E, 7'h7E, 7'h12, 7'h4F, 4'hF);
    run(32);

    tname = "lz_0040";
    do_load(16'h0040, 4'b1000, 4'hF, 1'b0, 1'b1, 7'h01, 7'h4C, 7'h7F, 7'h7F, 4'hF);
    run(32);

    tname = "lz_zero";
    do_load(16'h0000, 4'b0000, 4'hF, 1'b0, 1'b1, 7'h01, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    run(32);

    tname = "lz_live_off";
    lz_blank = 1'b0;
    set_tab(7'h01, 7'h01, 7'h01, 7'h01, 4'hF);
    run(32);

    tname = "load_mid_slot1";
    run_to(12);
    do_load(16'h3210, 4'b0001, 4'hF, 1'b0, 1'b0, 7'h01, 7'h4F, 7'h12, 7'h06, 4'b1110);
    run(32);

    tname = "dig_en_bcd";
    do_load(16'hC9E5, 4'b0000, 4'b1011, 1'b1, 1'b0, 7'h24, 7'h7E, 7'h7F, 7'h7E, 4'hF);
    run(32);

    tname = "back_to_back";
    value = 16'h8765; dp = 4'b0000; dig_en = 4'hF; bcd_mode = 1'b0; load = 1'b1;
    step();
    set_tab(7'h24, 7'h20, 7'h0F, 7'h00, 4'hF);
    value = 16'hDB00; dp = 4'b1010;
    step();
    load = 1'b0;
    set_tab(7'h01, 7'h01, 7'h60, 7'h42, 4'b0101);
    run(40);

    tname = "reset_mid_slot2";
    run_to(19);
    rst = 1'b1; load = 1'b1; value = 16'h1234; dig_en = 4'hF; dp = 4'hF;
    step();
    rst = 1'b0; load = 1'b0;
    set_tab(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF);
    tname = "blank_after_reset";
    run(40);

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending, want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
